sa_driver: RTL and testbench
============================

SA_DRIVER -- requirements
Module: sa_driver

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/sum width in bits (legal range 2..32).
REQ-002 SHALL have ports (clock and reset first):
- clk, in, 1: rising-edge clock, sole clock.
- reset, in, 1: asynchronous, active-low reset.
- start, in, 1: request to add; sampled only in IDLE.
- a_in, in, WIDTH: operand A; captured on an accepted start.
- b_in, in, WIDTH: operand B; captured on an accepted start.
- cin_in, in, 1: carry-in; captured on an accepted start.
- busy, out, 1: high in any state other than IDLE.
- done, out, 1: one-cycle pulse; sum, cout and err are valid.
- sum, out, WIDTH: parallel sum assembled from ser_s.
- cout, out, 1: final carry, tracked locally.
- err, out, 1: ser_s mismatched the local expected sum bit during the last operation.
- ser_clr, out, 1: active-high clear pulse to the bit-serial adder.
- ser_a, out, 1: serial operand A bit, LSB first.
- ser_b, out, 1: serial operand B bit, LSB first.
- ser_cin, out, 1: carry-in to the adder, held stable for the whole operation.
- ser_s, in, 1: registered sum bit from the adder, one cycle after ser_a/ser_b.

Function
REQ-003 SHALL implement FSM IDLE -> CLEAR -> SHIFT -> DONE -> IDLE.
REQ-004 IDLE: start=1 at a rising edge SHALL load a_in, b_in and cin_in into shift/hold registers, clear sum, and enter CLEAR.
REQ-005 CLEAR, exactly one cycle: ser_clr=1 and ser_a=ser_b=0; next state SHIFT with bit counter k=0.
REQ-006 SHIFT, WIDTH+1 cycles, k=0..WIDTH:
- k<WIDTH: ser_a/ser_b SHALL present operand bit k, driven from flops.
- k>=1: ser_s SHALL be captured as sum bit k-1, shifted in MSB-side so bit 0 ends at sum[0].
- k=WIDTH: ser_a=ser_b=0.
REQ-007 Local carry c SHALL initialise to the captured cin in CLEAR; for each presented bit, c <= maj(a_k, b_k, c).
REQ-008 Local expected bit e = a_k ^ b_k ^ c SHALL be pipelined one cycle and compared with the ser_s capture; any mismatch SHALL set err (sticky until the next accepted start).
REQ-009 DONE, exactly one cycle: done=1, cout=c; next state IDLE.
REQ-010 Latency: the start-accept edge is edge 0; done SHALL be high in the cycle after edge WIDTH+3.
REQ-011 sum, cout and err SHALL hold their values from DONE until the next accepted start.
REQ-012 start while busy=1 SHALL be ignored, with no queuing.
REQ-013 start held high continuously SHALL begin a new operation on the edge after DONE.
REQ-014 Operand changes on a_in, b_in or cin_in while busy SHALL not affect the operation in progress.
REQ-015 Addition is unsigned modulo 2^WIDTH; overflow is reported only via cout.

Reset
REQ-016 reset=0 SHALL asynchronously force IDLE, k=0, busy=0, done=0, sum=0, cout=0, err=0, ser_clr=0, ser_a=0, ser_b=0, ser_cin=0.
REQ-017 Reset asserted mid-operation SHALL abort the operation with no done pulse; after reset release the block accepts a new start normally.
REQ-018 All outputs SHALL be registered, with no combinational path from start to any output.

Structure
REQ-019 FSM state encoding and the CLEAR/DONE cycle-count constants SHALL live in shared package sa_pkg.
REQ-020 The parallel-in/serial-out operand register SHALL be a sub-module named sa_piso (WIDTH-parameterised, load/shift enable), instantiated twice, once for A and once for B.
REQ-021 The bench SHALL connect a behavioural bit-serial adder between ser_* and ser_s, with ser_clr used as its clear.

Verification (WIDTH=8)
REQ-022 a=0x35, b=0x4A, cin=0 -> done at cycle 11 after start; sum=0x7F, cout=0, err=0.
REQ-023 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; then a=0xFF, b=0x00, cin=1 -> sum=0x00, cout=1.
REQ-024 Bench adder forced to flip the ser_s bit captured at k=4 -> sum[3] differs from the expected value, err=1; the next clean operation -> err=0.
REQ-025 Second start pulses at cycles 3 and 7 of an operation with different operands -> ignored, and the result matches the first operands only.
REQ-026 reset driven low during SHIFT at k=5 -> all outputs 0 at once with no done pulse; start after release with a=0x10, b=0x20 -> sum=0x30.
REQ-027 start held high for 30 cycles with fixed operands -> back-to-back operations with done pulses exactly WIDTH+4 cycles apart.

Source files
------------

// File: rtl/sa_pkg.sv
// Shared types and constants for the bit-serial adder driver.
// FSM encoding, phase lengths and the carry helper.
package sa_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int CLEAR_CYCLES = 1;
    localparam int DONE_CYCLES  = 1;

    function automatic logic maj(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

endpackage

// File: rtl/sa_piso.sv
// Parallel-in / serial-out operand register, LSB first.
// Load has priority over shift; zeros fill from the MSB side.
module sa_piso #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             dout
);

    logic [WIDTH-1:0] q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (load) begin
            q <= din;
        end else if (shift) begin
            q <= {1'b0, q[WIDTH-1:1]};
        end
    end

    assign dout = q[0];

endmodule

// File: rtl/sa_driver.sv
// Drives a registered bit-serial adder and reassembles its sum.
// Serial outputs trail the FSM state by one registered cycle.
module sa_driver
    import sa_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             err,
    output logic             ser_clr,
    output logic             ser_a,
    output logic             ser_b,
    output logic             ser_cin,
    input  logic             ser_s
);

    localparam int KW = $clog2(WIDTH + 1);
    localparam logic [KW-1:0] K_LAST = KW'(WIDTH);
    localparam logic [KW-1:0] K_CLR  = KW'(CLEAR_CYCLES - 1);
    localparam logic [KW-1:0] K_DONE = KW'(DONE_CYCLES - 1);

    state_t state, state_n;
    logic [KW-1:0] k, k_n;
    logic accept, present;
    logic pa, pb;
    logic c, e_q, v1, v2;

    assign accept  = (state == IDLE) && start;
    assign present = (state == SHIFT) && (k < K_LAST);

    sa_piso #(.WIDTH(WIDTH)) u_piso_a (
        .clk   (clk),
        .reset (reset),
        .load  (accept),
        .shift (present),
        .din   (a_in),
        .dout  (pa)
    );

    sa_piso #(.WIDTH(WIDTH)) u_piso_b (
        .clk   (clk),
        .reset (reset),
        .load  (accept),
        .shift (present),
        .din   (b_in),
        .dout  (pb)
    );

    always_comb begin
        state_n = state;
        k_n     = k;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_n = CLEAR;
                    k_n     = '0;
                end
            end
            CLEAR: begin
                if (k == K_CLR) begin
                    state_n = SHIFT;
                    k_n     = '0;
                end else begin
                    k_n = k + 1'b1;
                end
            end
            SHIFT: begin
                if (k == K_LAST) begin
                    state_n = DONE;
                    k_n     = '0;
                end else begin
                    k_n = k + 1'b1;
                end
            end
            DONE: begin
                if (k == K_DONE) begin
                    state_n = IDLE;
                    k_n     = '0;
                end else begin
                    k_n = k + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                k_n     = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            k     <= '0;
            busy  <= 1'b0;
        end else begin
            state <= state_n;
            k     <= k_n;
            busy  <= (state_n != IDLE);
        end
    end

    // v1 marks a presented bit, v2 marks the cycle its ser_s returns
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            err     <= 1'b0;
            ser_clr <= 1'b0;
            ser_a   <= 1'b0;
            ser_b   <= 1'b0;
            ser_cin <= 1'b0;
            c       <= 1'b0;
            e_q     <= 1'b0;
            v1      <= 1'b0;
            v2      <= 1'b0;
        end else begin
            ser_clr <= (state == CLEAR);
            ser_a   <= present ? pa : 1'b0;
            ser_b   <= present ? pb : 1'b0;
            v1      <= present;
            v2      <= v1;
            done    <= (state == DONE);
            if (accept) begin
                sum     <= '0;
                cout    <= 1'b0;
                err     <= 1'b0;
                ser_cin <= cin_in;
            end
            if (state == CLEAR) begin
                c <= ser_cin;
            end else if (v1) begin
                c   <= maj(ser_a, ser_b, c);
                e_q <= ser_a ^ ser_b ^ c;
            end
            if (v2) begin
                sum <= {ser_s, sum[WIDTH-1:1]};
                if (ser_s != e_q) begin
                    err <= 1'b1;
                end
            end
            if (state == DONE) begin
                cout <= c;
            end
        end
    end

endmodule

// File: tb/tb_sa_driver.sv
// Directed bench for sa_driver with a behavioural serial adder.
// Expected values are hand computed for WIDTH=8.
module tb_sa_driver;

    localparam int WIDTH = 8;

    logic clk;
    logic reset;
    logic start;
    logic [WIDTH-1:0] a_in, b_in;
    logic cin_in;
    logic busy, done, cout, err;
    logic [WIDTH-1:0] sum;
    logic ser_clr, ser_a, ser_b, ser_cin, ser_s;

    int errs;
    int checks;

    logic inject;
    logic acc_c;
    int   acc_n;

    sa_driver #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .a_in    (a_in),
        .b_in    (b_in),
        .cin_in  (cin_in),
        .busy    (busy),
        .done    (done),
        .sum     (sum),
        .cout    (cout),
        .err     (err),
        .ser_clr (ser_clr),
        .ser_a   (ser_a),
        .ser_b   (ser_b),
        .ser_cin (ser_cin),
        .ser_s   (ser_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        ser_s = 1'b0;
        acc_c = 1'b0;
        acc_n = 0;
    end

    // registered bit-serial adder; inject flips the sum bit of index 3
    always @(posedge clk) begin
        if (ser_clr) begin
            acc_c <= ser_cin;
            ser_s <= 1'b0;
            acc_n <= 0;
        end else begin
            ser_s <= ser_a ^ ser_b ^ acc_c ^ (inject && acc_n == 3);
            acc_c <= (ser_a & ser_b) | (ser_a & acc_c) | (ser_b & acc_c);
            acc_n <= acc_n + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          input logic ci, input bit noise,
                          output int lat);
        a_in   = a;
        b_in   = b;
        cin_in = ci;
        start  = 1'b1;
        tick();
        start = 1'b0;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            if (noise) begin
                a_in   = 8'hAA;
                b_in   = 8'h55;
                cin_in = 1'b0;
                start  = (n == 4 || n == 8);
            end
            tick();
            if (done) begin
                lat = n;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic expect_result(input string tag, input logic [7:0] s,
                                 input logic co, input logic e,
                                 input int lat);
        chk({tag, "_lat"}, lat, 11);
        chk({tag, "_sum"}, sum, s);
        chk({tag, "_cout"}, cout, co);
        chk({tag, "_err"}, err, e);
        chk({tag, "_busy"}, busy, 0);
        tick();
        chk({tag, "_done_pulse"}, done, 0);
        chk({tag, "_sum_hold"}, sum, s);
    endtask

    int lat;
    int t1, t2;
    int dones;

    initial begin
        errs   = 0;
        checks = 0;
        inject = 1'b0;
        reset  = 1'b0;
        start  = 1'b0;
        a_in   = '0;
        b_in   = '0;
        cin_in = 1'b0;
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sum", sum, 0);
        chk("rst_ser", {ser_clr, ser_a, ser_b, ser_cin, cout, err}, 0);
        reset = 1'b1;
        tick();

        run_op(8'h35, 8'h4A, 1'b0, 1'b0, lat);
        expect_result("basic", 8'h7F, 1'b0, 1'b0, lat);

        run_op(8'hFF, 8'h01, 1'b0, 1'b0, lat);
        expect_result("ovf1", 8'h00, 1'b1, 1'b0, lat);
        run_op(8'hFF, 8'h00, 1'b1, 1'b0, lat);
        expect_result("ovf2", 8'h00, 1'b1, 1'b0, lat);

        inject = 1'b1;
        run_op(8'h12, 8'h34, 1'b0, 1'b0, lat);
        inject = 1'b0;
        expect_result("inject", 8'h4E, 1'b0, 1'b1, lat);
        run_op(8'h12, 8'h34, 1'b0, 1'b0, lat);
        expect_result("clean", 8'h46, 1'b0, 1'b0, lat);

        run_op(8'h0F, 8'h01, 1'b1, 1'b1, lat);
        expect_result("noise", 8'h11, 1'b0, 1'b0, lat);
        repeat (3) tick();
        chk("noise_no_queue", busy, 0);

        a_in   = 8'h3C;
        b_in   = 8'hC3;
        cin_in = 1'b0;
        start  = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        chk("pre_rst_busy", busy, 1);
        reset = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_sum", sum, 0);
        chk("abort_flags", {done, cout, err}, 0);
        chk("abort_ser", {ser_clr, ser_a, ser_b, ser_cin}, 0);
        dones = 0;
        for (int n = 0; n < 16; n++) begin
            if (n == 3) reset = 1'b1;
            tick();
            if (done) dones++;
        end
        chk("abort_no_done", dones, 0);
        run_op(8'h10, 8'h20, 1'b0, 1'b0, lat);
        expect_result("after_rst", 8'h30, 1'b0, 1'b0, lat);

        a_in   = 8'h01;
        b_in   = 8'h02;
        cin_in = 1'b0;
        start  = 1'b1;
        t1 = -1;
        t2 = -1;
        dones = 0;
        for (int t = 1; t <= 30; t++) begin
            tick();
            if (done) begin
                dones++;
                chk("b2b_sum", sum, 8'h03);
                if (t1 < 0) t1 = t;
                else if (t2 < 0) t2 = t;
            end
        end
        start = 1'b0;
        chk("b2b_count", dones, 2);
        chk("b2b_first", t1, 12);
        chk("b2b_period", t2 - t1, WIDTH + 4);
        dones = 0;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (done) dones++;
        end
        chk("b2b_tail", dones, 1);
        chk("b2b_idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
